// File: rtl/native_bridge_pkg.sv
// Shared definitions for native_register_bridge: register word offsets,
// CONFIG/STATUS bit positions and the bridge FSM state type.
package native_bridge_pkg;

    // Word offsets selected by req_addr[3:2]
    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_CONFIG = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_FIFO   = 2'd3;

    // CONFIG bit positions
    localparam int unsigned CFG_EN  = 0;
    localparam int unsigned CFG_DIR = 1;
    localparam int unsigned CFG_IRE = 2;

    // STATUS bit positions
    localparam int unsigned ST_LT1K  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_FULL  = 2;
    localparam int unsigned ST_WCNT  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FIFO_WAIT = 2'd1,
        RESP      = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/native_register_bridge.sv
// Single-beat req/rsp bus slave that decodes accesses into native core
// register strobes (COUNT/CONFIG load, FIFO push/pop) and returns read data.
// Optional feature: define NATIVE_BRIDGE_ERR_EN to report rsp_err on unmapped
// addresses, FIFO push when full and FIFO pop when empty.
module native_register_bridge
    import native_bridge_pkg::*;
#(
    parameter int ADDRW       = 4,
    parameter int FIFO_CNTW   = 9,
    parameter int FIFO_RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDRW-1:0]     req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 count_we,
    output logic [31:0]          count_in,
    output logic                 config_we,
    output logic                 en_in,
    output logic                 dir_in,
    output logic                 ire_in,
    output logic                 fifo_we,
    output logic [7:0]           fifo_data_in,
    output logic                 fifo_re,
    input  logic [31:0]          count_out,
    input  logic                 en_out,
    input  logic                 dir_out,
    input  logic                 ire_out,
    input  logic                 lt_1k_out,
    input  logic [7:0]           fifo_data_out,
    input  logic [FIFO_CNTW-1:0] fifo_word_count,
    input  logic                 fifo_empty,
    input  logic                 fifo_full
);

`ifdef NATIVE_BRIDGE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // Any request address bit above [3:2] marks the access as unmapped
    localparam logic [ADDRW-1:0] HI_MASK = ~ADDRW'(4'hF);

    bridge_state_t state, state_next;
    logic [1:0]    wait_cnt, wait_cnt_next;
    logic [31:0]   rdata_next;
    logic          err_next;
    logic          count_we_next, config_we_next, fifo_we_next, fifo_re_next;
    logic [31:0]   count_in_next;
    logic          en_in_next, dir_in_next, ire_in_next;
    logic [7:0]    fifo_data_in_next;
    logic          accept, unmapped;
    logic [1:0]    word;
    logic [31:0]   status_word;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

    assign req_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign word      = req_addr[3:2];
    assign unmapped  = |(req_addr & HI_MASK);

    // Assemble the read-only STATUS word from live FIFO/core flags
    always_comb begin
        status_word                       = '0;
        status_word[ST_WCNT +: FIFO_CNTW] = fifo_word_count;
        status_word[ST_FULL]              = fifo_full;
        status_word[ST_EMPTY]             = fifo_empty;
        status_word[ST_LT1K]              = lt_1k_out;
    end

    // Next-state, decode and registered-output logic
    always_comb begin
        state_next        = state;
        wait_cnt_next     = wait_cnt;
        rdata_next        = rsp_rdata;
        err_next          = rsp_err;
        count_we_next     = 1'b0;
        config_we_next    = 1'b0;
        fifo_we_next      = 1'b0;
        fifo_re_next      = 1'b0;
        count_in_next     = count_in;
        en_in_next        = en_in;
        dir_in_next       = dir_in;
        ire_in_next       = ire_in;
        fifo_data_in_next = fifo_data_in;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RESP;
                    rdata_next = '0;
                    err_next   = 1'b0;
                    if (unmapped) begin
                        err_next = ERR_EN;
                    end else begin
                        case (word)
                            REG_COUNT: begin
                                if (req_write) begin
                                    count_we_next = 1'b1;
                                    count_in_next = req_wdata;
                                end else begin
                                    rdata_next = count_out;
                                end
                            end
                            REG_CONFIG: begin
                                if (req_write) begin
                                    config_we_next = 1'b1;
                                    en_in_next     = req_wdata[CFG_EN];
                                    dir_in_next    = req_wdata[CFG_DIR];
                                    ire_in_next    = req_wdata[CFG_IRE];
                                end else begin
                                    rdata_next[CFG_EN]  = en_out;
                                    rdata_next[CFG_DIR] = dir_out;
                                    rdata_next[CFG_IRE] = ire_out;
                                end
                            end
                            REG_STATUS: begin
                                if (!req_write) begin
                                    rdata_next = status_word;
                                end
                            end
                            default: begin
                                if (req_write) begin
                                    if (fifo_full) begin
                                        err_next = ERR_EN;
                                    end else begin
                                        fifo_we_next      = 1'b1;
                                        fifo_data_in_next = req_wdata[7:0];
                                    end
                                end else if (fifo_empty) begin
                                    err_next = ERR_EN;
                                end else begin
                                    fifo_re_next  = 1'b1;
                                    wait_cnt_next = '0;
                                    state_next    = FIFO_WAIT;
                                end
                            end
                        endcase
                    end
                end
            end
            FIFO_WAIT: begin
                // fifo_re was high in the first FIFO_WAIT cycle; data is valid
                // FIFO_RD_LAT cycles after that, i.e. when wait_cnt reaches it
                if (wait_cnt == 2'(FIFO_RD_LAT)) begin
                    rdata_next = {24'b0, fifo_data_out};
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt + 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            count_we     <= 1'b0;
            config_we    <= 1'b0;
            fifo_we      <= 1'b0;
            fifo_re      <= 1'b0;
            count_in     <= '0;
            en_in        <= 1'b0;
            dir_in       <= 1'b0;
            ire_in       <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            state        <= state_next;
            wait_cnt     <= wait_cnt_next;
            rsp_rdata    <= rdata_next;
            rsp_err      <= err_next;
            count_we     <= count_we_next;
            config_we    <= config_we_next;
            fifo_we      <= fifo_we_next;
            fifo_re      <= fifo_re_next;
            count_in     <= count_in_next;
            en_in        <= en_in_next;
            dir_in       <= dir_in_next;
            ire_in       <= ire_in_next;
            fifo_data_in <= fifo_data_in_next;
        end
    end

endmodule
